// File: rtl/fifo4x8_pkg.sv
// fifo4x8_pkg: shared sizing constants and FSM state type for the
// 4-entry x 8-bit FIFO controller.
//   DEPTH - number of RAM entries
//   WIDTH - data width in bits
//   AW    - RAM address / pointer width
//   CW    - occupancy counter width (holds 0..DEPTH)
package fifo4x8_pkg;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int AW    = 2;
    localparam int CW    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo4x8_ptr.sv
// fifo4x8_ptr: write/read pointer and occupancy tracking for the FIFO.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   inc_wr, inc_rd   - advance write / read pointer this edge
//   wr_ptr, rd_ptr   - current RAM pointers (wrap 3->0)
//   count            - occupancy 0..DEPTH
//   full, empty      - count==DEPTH, count==0
// The caller only raises inc_wr when !full and inc_rd when !empty, so
// count stays inside 0..DEPTH without extra saturation.
module fifo4x8_ptr
    import fifo4x8_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_wr,
    input  logic          inc_rd,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (inc_wr) wr_ptr <= wr_ptr + AW'(1);
            if (inc_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({inc_wr, inc_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fifo4x8_ctrl.sv
// fifo4x8_ctrl: controller for a 4x8 FIFO built on an external single-port
// RAM with registered read data. Writes happen combinationally in IDLE;
// a pop takes RD1 (address), RD2 (RAM output valid), OUT (pop_valid pulse).
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   push_valid/push_data/push_ready - enqueue handshake
//   pop_req/pop_valid/pop_data  - dequeue request, one-cycle result pulse
//   count, full, empty          - occupancy status
//   ram_wr_en/ram_addr/ram_data_in  - RAM control
//   ram_data_out                - registered RAM read data
//   err[1:0] (only with FIFO4X8_CTRL_ERR_EN defined) - sticky
//                                 bit0 overflow, bit1 underflow
//
// state | meaning
// IDLE  | accepts pushes, or a pop when not empty (pop has priority)
// RD1   | RAM addressed with rd_ptr
// RD2   | RAM read data valid, captured on exit
// OUT   | pop_valid high for one cycle
module fifo4x8_ctrl
    import fifo4x8_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    input  logic             pop_req,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ram_wr_en,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_data_out
`ifdef FIFO4X8_CTRL_ERR_EN
    ,
    output logic [1:0]       err
`endif
);

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_accept;
    logic          push_accept;

    assign pop_accept  = (state == IDLE) && pop_req && !empty;
    // rst gating keeps the RAM write strobe low while reset is held.
    assign push_ready  = !rst && (state == IDLE) && !full && !(pop_req && !empty);
    assign push_accept = push_valid && push_ready;

    assign ram_wr_en   = push_accept;
    assign ram_data_in = push_data;
    assign ram_addr    = (state == RD1 || state == RD2) ? rd_ptr : wr_ptr;

    fifo4x8_ptr u_ptr (
        .clk    (clk),
        .rst    (rst),
        .inc_wr (push_accept),
        .inc_rd (state == RD2),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pop_valid <= 1'b0;
                    if (pop_accept) state <= RD1;
                end
                RD1: state <= RD2;
                RD2: begin
                    state     <= OUT;
                    pop_data  <= ram_data_out;
                    pop_valid <= 1'b1;
                end
                OUT: begin
                    state     <= IDLE;
                    pop_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    pop_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO4X8_CTRL_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 2'b00;
        end else begin
            if (push_valid && full)                  err[0] <= 1'b1;
            if ((state == IDLE) && pop_req && empty) err[1] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo4x8_ctrl.sv
// tb_fifo4x8_ctrl: self-checking bench for fifo4x8_ctrl with a behavioural
// RAM, a queue-based reference model and a scoreboard-driven pop monitor.
module tb_fifo4x8_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push_valid;
    logic [7:0] push_data;
    logic       push_ready;
    logic       pop_req;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       ram_wr_en;
    logic [1:0] ram_addr;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out = 8'h00;
`ifdef FIFO4X8_CTRL_ERR_EN
    logic [1:0] err;
`endif

    fifo4x8_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .push_valid   (push_valid),
        .push_data    (push_data),
        .push_ready   (push_ready),
        .pop_req      (pop_req),
        .pop_valid    (pop_valid),
        .pop_data     (pop_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .ram_wr_en    (ram_wr_en),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
`ifdef FIFO4X8_CTRL_ERR_EN
        ,
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with registered read data.
    logic [7:0] mem [4];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_data_in;
        ram_data_out <= mem[ram_addr];
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq[$];
    int         busy     = 0;   // cycles into an accepted read (0 = idle)
    int         wr_n     = 0;
    int         rd_n     = 0;
    logic [7:0] last_pop = 8'h00;
    logic [1:0] m_err    = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model.
    task automatic step(input logic pv, input logic [7:0] pd, input logic pr);
        int   sz;
        logic exp_ready;
        logic push_acc;
        logic pop_acc;
        @(negedge clk);
        push_valid = pv;
        push_data  = pd;
        pop_req    = pr;
        #1;
        sz        = mq.size();
        exp_ready = (busy == 0) && (sz < 4) && !(pr && sz > 0);
        push_acc  = exp_ready && pv;
        pop_acc   = (busy == 0) && pr && (sz > 0);
        chk("push_ready", push_ready, exp_ready);
        chk("ram_wr_en", ram_wr_en, push_acc);
        chk("count", count, sz);
        chk("full", full, sz == 4);
        chk("empty", empty, sz == 0);
        if (push_acc) chk("ram_data_in", ram_data_in, pd);
        if (busy == 0) chk("ram_addr_wr", ram_addr, wr_n);
        else if (busy == 1 || busy == 2) chk("ram_addr_rd", ram_addr, rd_n);
`ifdef FIFO4X8_CTRL_ERR_EN
        chk("err", err, m_err);
        if (pv && sz == 4) m_err[0] = 1'b1;
        if (busy == 0 && pr && sz == 0) m_err[1] = 1'b1;
`endif
        case (busy)
            0: if (pop_acc) begin
                sb.push_back('{mq[0], cyc + 3});
                busy = 1;
            end
            1: busy = 2;
            2: begin
                void'(mq.pop_front());
                rd_n = (rd_n + 1) % 4;
                busy = 3;
            end
            default: busy = 0;
        endcase
        if (push_acc) begin
            mq.push_back(pd);
            wr_n = (wr_n + 1) % 4;
        end
    endtask

    task automatic pop_one();
        step(1'b0, 8'h00, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0);
    endtask

    // Assert reset now and check that it acts without a clock edge.
    task automatic reset_checks();
        rst = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_ram_wr_en", ram_wr_en, 0);
`ifdef FIFO4X8_CTRL_ERR_EN
        chk("rst_err", err, 0);
`endif
        mq.delete();
        sb.delete();
        busy     = 0;
        wr_n     = 0;
        rd_n     = 0;
        last_pop = 8'h00;
        m_err    = 2'b00;
    endtask

    // Pop monitor: every pop_valid must match the oldest expected pop, on
    // the expected cycle; otherwise pop_data must hold its last value.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (pop_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pop_data", pop_data, e.data);
                    chk("pop_latency", cyc, e.due);
                    last_pop = e.data;
                end
            end else if (rst === 1'b0) begin
                chk("pop_data_hold", pop_data, last_pop);
            end
        end
    end

    logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        rst        = 1'b1;
        push_valid = 1'b1;
        push_data  = 8'hAB;
        pop_req    = 1'b1;
        #2;
        reset_checks();
        @(negedge clk);
        rst        = 1'b0;
        push_valid = 1'b0;
        pop_req    = 1'b0;

        // Fill to full, then a fifth push that must be ignored.
        for (int i = 0; i < 4; i++) step(1'b1, fill[i], 1'b0);
        step(1'b1, 8'h99, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Drain in order.
        repeat (4) pop_one();
        step(1'b0, 8'h00, 1'b0);

        // Pointer wrap with interleaved pops.
        step(1'b1, 8'hA0, 1'b0);
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        pop_one();
        step(1'b1, 8'hA3, 1'b0);
        pop_one();
        step(1'b1, 8'hA4, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        repeat (4) pop_one();
        step(1'b0, 8'h00, 1'b0);

        // Pop wins over a coincident push; the push completes after OUT.
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h55, 1'b1);
        repeat (3) step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        pop_one();
        step(1'b0, 8'h00, 1'b0);

        // Reset while the read is in RD2.
        step(1'b1, 8'h66, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset_checks();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step(1'b0, 8'h00, 1'b0);

        // Pop on empty is ignored.
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Randomized traffic.
        repeat (400) step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 3));

        repeat (6) step(1'b0, 8'h00, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
